lpc_cycle_decoder: RTL and testbench

Upstream front-end of the LPC sniffer. It passively decodes LPC host-initiated IO and memory cycles from lpc_ad and lpc_frame. For each completed transfer it presents the cycle type/direction, the address and the data byte, and pulses a one-cycle latch. That output feeds the lpc-to-memory packer. It never drives the bus.

---
 rtl/lpc_pkg.sv | 27 ++
 rtl/lpc_cycle_decoder.sv | 143 ++++++++++++++
 tb/tb_lpc_cycle_decoder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lpc_pkg.sv
// Shared LPC decoder types: FSM states, cycle types,
// SYNC codes and START nibbles.
package lpc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CYCTYPE,
    ST_ADDR,
    ST_WDATA,
    ST_TAR,
    ST_SYNC,
    ST_RDATA
  } lpc_state_t;

  localparam logic [1:0] CYC_IO  = 2'b00;
  localparam logic [1:0] CYC_MEM = 2'b01;

  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_SHORT = 4'b0101;
  localparam logic [3:0] SYNC_LONG  = 4'b0110;
  localparam logic [3:0] SYNC_ERR   = 4'b1010;

  localparam logic [3:0] START_TARGET = 4'b0000;
  localparam logic [3:0] START_ABORT  = 4'b1111;

endpackage

// File: rtl/lpc_cycle_decoder.sv
// Passive LPC IO/memory cycle decoder: reports each completed
// host transfer with a one-cycle latch, or an error pulse.
module lpc_cycle_decoder
  import lpc_pkg::*;
#(
  parameter int SYNC_TIMEOUT     = 255,
  parameter int IO_ADDR_NIBBLES  = 4,
  parameter int MEM_ADDR_NIBBLES = 8
) (
  input  logic        lpc_clock,
  input  logic        lpc_reset,
  input  logic [3:0]  lpc_ad,
  input  logic        lpc_frame,
  output logic [3:0]  out_cyctype_dir,
  output logic [31:0] out_addr,
  output logic [7:0]  out_data,
  output logic        out_latch,
  output logic        out_error
);

  localparam int NW = $clog2(MEM_ADDR_NIBBLES + 1);
  localparam int WW = $clog2(SYNC_TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SYNC_TIMEOUT - 1);

  lpc_state_t    state;
  logic [NW-1:0] nib_cnt;
  logic [WW-1:0] wait_cnt;
  logic [31:0]   addr_sh;
  logic [7:0]    data_sh;
  logic [1:0]    cyc_type;
  logic          is_write;
  logic          busy;

  assign busy = state inside {ST_ADDR, ST_WDATA, ST_TAR,
                              ST_SYNC, ST_RDATA};

  always_ff @(posedge lpc_clock or negedge lpc_reset) begin
    if (!lpc_reset) begin
      state           <= ST_IDLE;
      nib_cnt         <= '0;
      wait_cnt        <= '0;
      addr_sh         <= '0;
      data_sh         <= '0;
      cyc_type        <= CYC_IO;
      is_write        <= 1'b0;
      out_cyctype_dir <= '0;
      out_addr        <= '0;
      out_data        <= '0;
      out_latch       <= 1'b0;
      out_error       <= 1'b0;
    end else begin
      out_latch <= 1'b0;
      out_error <= 1'b0;
      if (!lpc_frame) begin
        state     <= (lpc_ad == START_TARGET) ? ST_START : ST_IDLE;
        out_error <= busy && (lpc_ad == START_TARGET ||
                              lpc_ad == START_ABORT);
      end else begin
        unique case (state)
          // The cyctype nibble is on the first frame-high edge
          // after START, so it is decoded here directly.
          ST_START: begin
            if ((lpc_ad[3:2] == CYC_IO || lpc_ad[3:2] == CYC_MEM)
                && !lpc_ad[0]) begin
              cyc_type <= lpc_ad[3:2];
              is_write <= lpc_ad[1];
              addr_sh  <= '0;
              nib_cnt  <= (lpc_ad[3:2] == CYC_MEM) ?
                          NW'(MEM_ADDR_NIBBLES) :
                          NW'(IO_ADDR_NIBBLES);
              state    <= ST_ADDR;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_ADDR: begin
            addr_sh <= {addr_sh[27:0], lpc_ad};
            nib_cnt <= nib_cnt - 1'b1;
            if (nib_cnt == NW'(1)) begin
              nib_cnt <= NW'(2);
              state   <= is_write ? ST_WDATA : ST_TAR;
            end
          end
          ST_WDATA: begin
            data_sh <= {lpc_ad, data_sh[7:4]};
            nib_cnt <= nib_cnt - 1'b1;
            if (nib_cnt == NW'(1)) begin
              nib_cnt <= NW'(2);
              state   <= ST_TAR;
            end
          end
          ST_TAR: begin
            nib_cnt <= nib_cnt - 1'b1;
            if (nib_cnt == NW'(1)) begin
              wait_cnt <= '0;
              state    <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            unique case (lpc_ad)
              SYNC_READY: begin
                if (is_write) begin
                  out_cyctype_dir <= {cyc_type, 2'b10};
                  out_addr        <= addr_sh;
                  out_data        <= data_sh;
                  out_latch       <= 1'b1;
                  state           <= ST_IDLE;
                end else begin
                  nib_cnt <= NW'(2);
                  state   <= ST_RDATA;
                end
              end
              SYNC_ERR: begin
                out_error <= 1'b1;
                state     <= ST_IDLE;
              end
              default: begin
                wait_cnt <= wait_cnt + 1'b1;
                if (wait_cnt == WAIT_LAST) begin
                  out_error <= 1'b1;
                  state     <= ST_IDLE;
                end
              end
            endcase
          end
          ST_RDATA: begin
            data_sh <= {lpc_ad, data_sh[7:4]};
            nib_cnt <= nib_cnt - 1'b1;
            if (nib_cnt == NW'(1)) begin
              out_cyctype_dir <= {cyc_type, 2'b00};
              out_addr        <= addr_sh;
              out_data        <= {lpc_ad, data_sh[7:4]};
              out_latch       <= 1'b1;
              state           <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// Scoreboard bench for lpc_cycle_decoder: directed LPC
// transactions push expected pulses, a monitor pops and checks.
module tb_lpc_cycle_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ad = 4'hF;
  logic        frame = 1'b1;
  logic [3:0]  cyc_dir;
  logic [31:0] addr;
  logic [7:0]  data;
  logic        latch;
  logic        err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        is_err;
    logic [3:0]  cyc;
    logic [31:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t q[$];

  lpc_cycle_decoder #(
    .SYNC_TIMEOUT(255),
    .IO_ADDR_NIBBLES(4),
    .MEM_ADDR_NIBBLES(8)
  ) dut (
    .lpc_clock(clk),
    .lpc_reset(rst_n),
    .lpc_ad(ad),
    .lpc_frame(frame),
    .out_cyctype_dir(cyc_dir),
    .out_addr(addr),
    .out_data(data),
    .out_latch(latch),
    .out_error(err)
  );

  always #15 clk = ~clk;

  always @(negedge clk) begin
    if (latch && err) begin
      checks++;
      failures++;
      $display("FAIL both_pulses latch=%0b error=%0b required one",
               latch, err);
    end else if (latch || err) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse latch=%0b error=%0b required none",
                 latch, err);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (err !== e.is_err || cyc_dir !== e.cyc ||
            addr !== e.addr || data !== e.data) begin
          failures++;
          $display("FAIL pulse got err=%0b cyc=%b addr=%h data=%h required err=%0b cyc=%b addr=%h data=%h",
                   err, cyc_dir, addr, data,
                   e.is_err, e.cyc, e.addr, e.data);
        end
      end
    end
  end

  task automatic push(input logic is_err, input logic [3:0] c,
                      input logic [31:0] a, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.cyc = c;
    e.addr = a;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic nib(input logic f, input logic [3:0] a);
    @(negedge clk);
    frame = f;
    ad = a;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) nib(1'b1, 4'hF);
  endtask

  task automatic hdr(input logic [3:0] c, input logic [31:0] a,
                     input int n);
    nib(1'b0, 4'h0);
    nib(1'b1, c);
    for (int i = n - 1; i >= 0; i--) nib(1'b1, a[4*i +: 4]);
  endtask

  task automatic wr_tail(input logic [7:0] d, input int waits,
                         input logic [3:0] wcode,
                         input logic [3:0] code);
    nib(1'b1, d[3:0]);
    nib(1'b1, d[7:4]);
    idle(2);
    for (int i = 0; i < waits; i++) nib(1'b1, wcode);
    nib(1'b1, code);
  endtask

  task automatic rd_tail(input logic [7:0] d, input int waits,
                         input logic [3:0] wcode);
    idle(2);
    for (int i = 0; i < waits; i++) nib(1'b1, wcode);
    nib(1'b1, 4'h0);
    nib(1'b1, d[3:0]);
    nib(1'b1, d[7:4]);
  endtask

  task automatic chk_out(input string name, input logic [44:0] req);
    checks++;
    if ({cyc_dir, addr, data, latch} !== req) begin
      failures++;
      $display("FAIL %s got %h required %h", name,
               {cyc_dir, addr, data, latch}, req);
    end
  endtask

  initial begin
    #40;
    chk_out("reset_state", '0);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL reset_error got %0b required 0", err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // 1: IO write 0x0080 <- 0x5A
    push(0, 4'b0010, 32'h0000_0080, 8'h5A);
    hdr(4'b0010, 32'h0080, 4);
    wr_tail(8'h5A, 0, 4'h6, 4'h0);
    idle(3);

    // 2: memory read 0xFFFFFFF0, 3 long waits, data 0xA5
    push(0, 4'b0100, 32'hFFFF_FFF0, 8'hA5);
    hdr(4'b0100, 32'hFFFF_FFF0, 8);
    rd_tail(8'hA5, 3, 4'h6);
    idle(3);

    // 3: IO read aborted after 2 address nibbles
    push(1, 4'b0100, 32'hFFFF_FFF0, 8'hA5);
    hdr(4'b0000, 32'h0000_0012, 2);
    nib(1'b0, 4'hF);
    idle(2);
    push(0, 4'b0010, 32'h0000_002E, 8'h11);
    hdr(4'b0010, 32'h002E, 4);
    wr_tail(8'h11, 0, 4'h6, 4'h0);
    idle(3);

    // 4: memory write with SYNC error, then timeout
    push(1, 4'b0010, 32'h0000_002E, 8'h11);
    hdr(4'b0110, 32'h1234_5678, 8);
    wr_tail(8'h3C, 2, 4'h5, 4'hA);
    idle(3);
    push(1, 4'b0010, 32'h0000_002E, 8'h11);
    hdr(4'b0110, 32'h8765_4321, 8);
    wr_tail(8'hC3, 256, 4'h6, 4'h0);
    idle(3);

    // restart during write data, new START continues as IO read
    push(1, 4'b0010, 32'h0000_002E, 8'h11);
    push(0, 4'b0000, 32'h0000_0071, 8'hC3);
    hdr(4'b0010, 32'h0070, 4);
    nib(1'b1, 4'h9);
    hdr(4'b0000, 32'h0071, 4);
    rd_tail(8'hC3, 1, 4'h5);
    idle(3);

    // 5: DMA cyctype ignored, then IO read and back-to-back write
    hdr(4'b1000, 32'h0000_0000, 0);
    nib(1'b1, 4'h0);
    nib(1'b1, 4'h3);
    idle(4);
    push(0, 4'b0000, 32'h0000_0060, 8'h42);
    push(0, 4'b0010, 32'h0000_0064, 8'hF0);
    hdr(4'b0000, 32'h0060, 4);
    rd_tail(8'h42, 1, 4'h5);
    hdr(4'b0010, 32'h0064, 4);
    wr_tail(8'hF0, 1, 4'h3, 4'h0);
    idle(3);

    // 6: reset asserted mid-address
    hdr(4'b0010, 32'h03F8, 2);
    #5;
    rst_n = 1'b0;
    #1;
    chk_out("reset_mid_addr", '0);
    idle(2);
    rst_n = 1'b1;
    idle(2);
    push(0, 4'b0010, 32'h0000_03F8, 8'h7E);
    hdr(4'b0010, 32'h03F8, 4);
    wr_tail(8'h7E, 0, 4'h6, 4'h0);
    idle(5);

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses got %0d pending required 0",
               q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
